// File: rtl/valid_ready_link.sv
`timescale 1ns/1ps
// valid_ready_link: valid/ready source and sink halves in one block.
// The master sends an incrementing data stream. The slave throttles it with a
// repeating ready pattern, captures each accepted beat and checks it against
// a running expected value. The two halves are connected outside the block.
module valid_ready_link #(
   parameter int unsigned       DATA_W        = 32,
   parameter logic [DATA_W-1:0] DATA_INIT     = 1,
   parameter int unsigned       NUM_XFERS     = 16,
   parameter logic [7:0]        READY_PATTERN = 8'b1011_0110
) (
   input  logic              clk,
   input  logic              rst,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              data_success,
   output logic [DATA_W-1:0] rx_data,
   output logic [15:0]       rx_count,
   output logic              tx_done,
   output logic              error
);

   typedef enum logic [1:0] {
      M_IDLE,
      M_SEND,
      M_DONE
   } m_state_e;

   m_state_e          m_state_q;
   logic [DATA_W-1:0] m_data_q;
   logic              m_valid_q;
   logic              tx_done_q;
   logic [31:0]       sent_q;
   logic [31:0]       sent_d;

   logic [2:0]        idx_q;
   logic              s_ready_q;
   logic              ds_q;
   logic [DATA_W-1:0] rx_data_q;
   logic [15:0]       rx_count_q;
   logic              error_q;
   logic [DATA_W-1:0] expected_q;
   logic              accept_d;

   // Next sent count and slave accept condition, both from registered state
   // and edge-sampled inputs only.
   always_comb begin
      sent_d   = sent_q + 32'd1;
      accept_d = s_valid & s_ready_q;
   end

   // Master FSM: start once after reset, hold data until handshake, stop after
   // NUM_XFERS beats (never when NUM_XFERS is 0).
   always_ff @(posedge clk) begin
      if (rst) begin
         m_state_q <= M_IDLE;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         tx_done_q <= 1'b0;
         sent_q    <= '0;
      end else begin
         case (m_state_q)
            M_IDLE: begin
               m_valid_q <= 1'b1;
               m_data_q  <= DATA_INIT;
               sent_q    <= '0;
               m_state_q <= M_SEND;
            end
            M_SEND: begin
               // m_valid_q is always 1 here, so m_ready alone marks a handshake
               if (m_ready) begin
                  sent_q <= sent_d;
                  if ((NUM_XFERS != 0) && (sent_d == NUM_XFERS)) begin
                     m_valid_q <= 1'b0;
                     tx_done_q <= 1'b1;
                     m_state_q <= M_DONE;
                  end else begin
                     m_data_q <= m_data_q + DATA_W'(1);
                  end
               end
            end
            M_DONE: begin
               m_valid_q <= 1'b0;
               tx_done_q <= 1'b1;
            end
            default: m_state_q <= M_IDLE;
         endcase
      end
   end

   // Slave: free-running ready pattern, capture and check on each accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q      <= '0;
         s_ready_q  <= 1'b0;
         ds_q       <= 1'b0;
         rx_data_q  <= '0;
         rx_count_q <= '0;
         error_q    <= 1'b0;
         expected_q <= DATA_INIT;
      end else begin
         s_ready_q <= READY_PATTERN[idx_q];
         idx_q     <= idx_q + 3'd1;
         ds_q      <= accept_d;
         if (accept_d) begin
            rx_data_q  <= s_data;
            rx_count_q <= rx_count_q + 16'd1;
            expected_q <= expected_q + DATA_W'(1);
            if (s_data != expected_q) begin
               error_q <= 1'b1;
            end
         end
      end
   end

   assign m_data       = m_data_q;
   assign m_valid      = m_valid_q;
   assign tx_done      = tx_done_q;
   assign s_ready      = s_ready_q;
   assign data_success = ds_q;
   assign rx_data      = rx_data_q;
   assign rx_count     = rx_count_q;
   assign error        = error_q;

endmodule

// File: tb/tb_valid_ready_link.sv
`timescale 1ns/1ps
// Directed bench for valid_ready_link: full-throughput instance, default
// pattern instance, default pattern with 11 ns skew on ready, plus corruption
// and mid-stream reset on the full-throughput instance.
module tb_valid_ready_link;

   localparam logic [7:0] PAT_DEF = 8'b1011_0110;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic corrupt = 1'b0;

   int checks = 0;
   int errors = 0;

   // full-throughput instance (pattern all ones)
   logic [31:0] ff_mdata, ff_sdata, ff_rx;
   logic        ff_mvalid, ff_sready, ff_ds, ff_done, ff_err;
   logic [15:0] ff_cnt;
   assign ff_sdata = ff_mdata ^ {31'b0, corrupt};

   // default pattern, direct loop
   logic [31:0] df_mdata, df_rx;
   logic        df_mvalid, df_sready, df_ds, df_done, df_err;
   logic [15:0] df_cnt;

   // default pattern, ready looped through 11 ns delay
   logic [31:0] sk_mdata, sk_rx;
   logic        sk_mvalid, sk_sready, sk_ds, sk_done, sk_err;
   logic        sk_mready = 1'b0;
   logic [15:0] sk_cnt;

   valid_ready_link #(.DATA_W(32), .DATA_INIT(32'd1), .NUM_XFERS(16), .READY_PATTERN(8'hFF)) u_ff (
      .clk(clk), .rst(rst), .m_data(ff_mdata), .m_valid(ff_mvalid), .m_ready(ff_sready),
      .s_data(ff_sdata), .s_valid(ff_mvalid), .s_ready(ff_sready), .data_success(ff_ds),
      .rx_data(ff_rx), .rx_count(ff_cnt), .tx_done(ff_done), .error(ff_err));

   valid_ready_link #(.DATA_W(32), .DATA_INIT(32'd1), .NUM_XFERS(16), .READY_PATTERN(PAT_DEF)) u_df (
      .clk(clk), .rst(rst), .m_data(df_mdata), .m_valid(df_mvalid), .m_ready(df_sready),
      .s_data(df_mdata), .s_valid(df_mvalid), .s_ready(df_sready), .data_success(df_ds),
      .rx_data(df_rx), .rx_count(df_cnt), .tx_done(df_done), .error(df_err));

   valid_ready_link #(.DATA_W(32), .DATA_INIT(32'd1), .NUM_XFERS(16), .READY_PATTERN(PAT_DEF)) u_sk (
      .clk(clk), .rst(rst), .m_data(sk_mdata), .m_valid(sk_mvalid), .m_ready(sk_mready),
      .s_data(sk_mdata), .s_valid(sk_mvalid), .s_ready(sk_sready), .data_success(sk_ds),
      .rx_data(sk_rx), .rx_count(sk_cnt), .tx_done(sk_done), .error(sk_err));

   always #50 clk = ~clk;

   // ready reaches the skewed master 11 ns after the slave drives it
   always @(posedge clk) begin
      #11;
      sk_mready <= sk_sready;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [7:0] pat;
   int  bf, bd;
   logic acc_f, acc_d, mvd_prev, sr_prev, sr_exp;

   initial begin
      pat = PAT_DEF;
      bf = 0; bd = 0; sr_prev = 1'b0;

      // reset held for 3 cycles
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ff_mvalid", 32'(ff_mvalid), 32'd0);
      chk("rst_ff_mdata",  ff_mdata,       32'd0);
      chk("rst_ff_sready", 32'(ff_sready), 32'd0);
      chk("rst_ff_ds",     32'(ff_ds),     32'd0);
      chk("rst_ff_cnt",    32'(ff_cnt),    32'd0);
      chk("rst_ff_rx",     ff_rx,          32'd0);
      chk("rst_ff_err",    32'(ff_err),    32'd0);
      chk("rst_ff_done",   32'(ff_done),   32'd0);
      chk("rst_df_mvalid", 32'(df_mvalid), 32'd0);
      chk("rst_df_sready", 32'(df_sready), 32'd0);
      chk("rst_df_cnt",    32'(df_cnt),    32'd0);
      rst = 1'b0;

      // main run: n is the edge count after reset release
      for (int n = 1; n <= 30; n++) begin
         acc_f    = (n >= 2) && (bf < 16);
         mvd_prev = (n >= 2) && (bd < 16);
         acc_d    = mvd_prev && sr_prev;
         if (acc_f) bf++;
         if (acc_d) bd++;
         sr_exp = pat[(n - 1) % 8];
         @(posedge clk);
         #1;
         chk($sformatf("ff_ds@%0d", n),     32'(ff_ds),     32'(acc_f));
         chk($sformatf("ff_rx@%0d", n),     ff_rx,          32'(bf));
         chk($sformatf("ff_cnt@%0d", n),    32'(ff_cnt),    32'(bf));
         chk($sformatf("ff_mvalid@%0d", n), 32'(ff_mvalid), 32'(bf < 16));
         chk($sformatf("ff_done@%0d", n),   32'(ff_done),   32'(bf == 16));
         chk($sformatf("ff_err@%0d", n),    32'(ff_err),    32'd0);
         if (bf < 16) chk($sformatf("ff_mdata@%0d", n), ff_mdata, 32'(bf + 1));

         chk($sformatf("df_sready@%0d", n), 32'(df_sready), 32'(sr_exp));
         chk($sformatf("df_ds@%0d", n),     32'(df_ds),     32'(acc_d));
         chk($sformatf("df_rx@%0d", n),     df_rx,          32'(bd));
         chk($sformatf("df_cnt@%0d", n),    32'(df_cnt),    32'(bd));
         chk($sformatf("df_mvalid@%0d", n), 32'(df_mvalid), 32'(bd < 16));
         chk($sformatf("df_done@%0d", n),   32'(df_done),   32'(bd == 16));
         chk($sformatf("df_err@%0d", n),    32'(df_err),    32'd0);
         if (bd < 16) chk($sformatf("df_mdata@%0d", n), df_mdata, 32'(bd + 1));

         chk($sformatf("sk_sready@%0d", n), 32'(sk_sready), 32'(sr_exp));
         chk($sformatf("sk_ds@%0d", n),     32'(sk_ds),     32'(acc_d));
         chk($sformatf("sk_rx@%0d", n),     sk_rx,          32'(bd));
         chk($sformatf("sk_cnt@%0d", n),    32'(sk_cnt),    32'(bd));
         chk($sformatf("sk_mvalid@%0d", n), 32'(sk_mvalid), 32'(bd < 16));
         chk($sformatf("sk_done@%0d", n),   32'(sk_done),   32'(bd == 16));
         chk($sformatf("sk_err@%0d", n),    32'(sk_err),    32'd0);
         if (bd < 16) chk($sformatf("sk_mdata@%0d", n), sk_mdata, 32'(bd + 1));
         sr_prev = sr_exp;
      end

      // corruption: bit0 of beat 3 inverted on the full-throughput instance
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      for (int n = 1; n <= 6; n++) begin
         @(posedge clk);
         #1;
         chk($sformatf("cr_ds@%0d", n),  32'(ff_ds),  32'(n >= 2));
         chk($sformatf("cr_cnt@%0d", n), 32'(ff_cnt), 32'(n - 1));
         chk($sformatf("cr_rx@%0d", n),  ff_rx,       (n == 4) ? 32'd2 : 32'(n - 1));
         chk($sformatf("cr_err@%0d", n), 32'(ff_err), 32'(n >= 4));
         corrupt = (n == 3);
      end

      // mid-stream reset after 5 accepted beats
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mr_mvalid", 32'(ff_mvalid), 32'd0);
      chk("mr_cnt",    32'(ff_cnt),    32'd0);
      chk("mr_rx",     ff_rx,          32'd0);
      chk("mr_err",    32'(ff_err),    32'd0);
      chk("mr_ds",     32'(ff_ds),     32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("mr1_mvalid", 32'(ff_mvalid), 32'd1);
      chk("mr1_mdata",  ff_mdata,       32'd1);
      chk("mr1_ds",     32'(ff_ds),     32'd0);
      @(posedge clk);
      #1;
      chk("mr2_ds",  32'(ff_ds),  32'd1);
      chk("mr2_rx",  ff_rx,       32'd1);
      chk("mr2_cnt", 32'(ff_cnt), 32'd1);
      chk("mr2_err", 32'(ff_err), 32'd0);
      @(posedge clk);
      #1;
      chk("mr3_rx",  ff_rx,       32'd2);
      chk("mr3_cnt", 32'(ff_cnt), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
